// File: rtl/uart_core_param.sv
// uart_core_param -- parametrised full-duplex UART (8N1 by default).
//
// Single clock domain. A free-running divider produces a one-cycle tick
// OVERSAMPLE times per bit; TX and RX both advance on that tick only.
//
// Ports:
//   sysclk         system clock, rising edge
//   reset          asynchronous assert, active-low
//   tx_data        word to send, captured when tx_valid & tx_ready
//   tx_valid       send request
//   tx_ready       transmitter idle
//   uart_tx        serial output, idle high
//   uart_rx        serial input, asynchronous to sysclk
//   rx_data        last good received word
//   rx_valid       one-cycle pulse, rx_data updated
//   rx_frame_err   one-cycle pulse, stop bit sampled low
//   rx_parity_err  one-cycle pulse, parity mismatch (0 without parity)
//
// Compile option: define UART_PARITY_EN to insert a parity bit after the
// data bits in both directions (PARITY_ODD selects odd parity).

module uart_core_param #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic                 sysclk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 uart_tx,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err
);

   localparam int DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE);
   localparam int TW  = $clog2(DIV);
   localparam int OW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS);
   localparam logic [TW-1:0] T_LAST  = TW'(DIV-1);
   localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE-1);
   localparam logic [OW-1:0] OS_MID  = OW'(OVERSAMPLE/2-1);
   localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS-1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
      $error("DATA_BITS must be in 5..9");
   end
   if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_chk_os
      $error("OVERSAMPLE must be even and >= 8");
   end
   if (DIV < 2) begin : g_chk_div
      $error("CLK_HZ too low for BAUD*OVERSAMPLE");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_chk_par
      $error("PARITY_ODD must be 0 or 1");
   end

   // ---------------- shared tick ----------------
   logic [TW-1:0] tcnt;
   logic          tick;

   assign tick = (tcnt == T_LAST);

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) tcnt <= '0;
      else        tcnt <= tick ? '0 : tcnt + 1'b1;
   end

   // ---------------- transmitter ----------------
   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
      TX_PAR,
`endif
      TX_STOP
   } tx_state_t;

   tx_state_t            tx_state;
   logic [OW-1:0]        tx_os;
   logic [BW-1:0]        tx_bit;
   logic [DATA_BITS-1:0] tx_sh;
`ifdef UART_PARITY_EN
   logic                 tx_par;
`endif

   // Each non-idle bit ends on its OVERSAMPLE-th tick; the next bit's line
   // level is registered on that same edge so uart_tx is glitch-free.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         tx_state <= TX_IDLE;
         tx_os    <= '0;
         tx_bit   <= '0;
         tx_sh    <= '0;
         uart_tx  <= 1'b1;
         tx_ready <= 1'b1;
`ifdef UART_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (tx_valid) begin
                  tx_sh    <= tx_data;
                  tx_os    <= '0;
                  tx_ready <= 1'b0;
                  uart_tx  <= 1'b0;
                  tx_state <= TX_START;
`ifdef UART_PARITY_EN
                  tx_par   <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
               end
            end
            default: begin
               if (tick) begin
                  if (tx_os != OS_LAST) begin
                     tx_os <= tx_os + 1'b1;
                  end else begin
                     tx_os <= '0;
                     case (tx_state)
                        TX_START: begin
                           tx_bit   <= '0;
                           uart_tx  <= tx_sh[0];
                           tx_state <= TX_DATA;
                        end
                        TX_DATA: begin
                           if (tx_bit != B_LAST) begin
                              tx_bit  <= tx_bit + 1'b1;
                              tx_sh   <= {1'b0, tx_sh[DATA_BITS-1:1]};
                              uart_tx <= tx_sh[1];
                           end else begin
`ifdef UART_PARITY_EN
                              uart_tx  <= tx_par;
                              tx_state <= TX_PAR;
`else
                              uart_tx  <= 1'b1;
                              tx_state <= TX_STOP;
`endif
                           end
                        end
`ifdef UART_PARITY_EN
                        TX_PAR: begin
                           uart_tx  <= 1'b1;
                           tx_state <= TX_STOP;
                        end
`endif
                        TX_STOP: begin
                           tx_ready <= 1'b1;
                           tx_state <= TX_IDLE;
                        end
                        default: tx_state <= TX_IDLE;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   // ---------------- receiver ----------------
   logic rx_meta, rx_s;

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_s    <= rx_meta;
      end
   end

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
      RX_PAR,
`endif
      RX_STOP, RX_BREAK
   } rx_state_t;

   rx_state_t            rx_state;
   logic [OW-1:0]        rx_os;
   logic [BW-1:0]        rx_bit;
   logic [DATA_BITS-1:0] rx_sh;
`ifdef UART_PARITY_EN
   logic                 rx_perr;
`else
   assign rx_parity_err = 1'b0;
`endif

   // START re-samples half a bit in; from then on every sample lands mid-bit.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         rx_state     <= RX_IDLE;
         rx_os        <= '0;
         rx_bit       <= '0;
         rx_sh        <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
         rx_perr       <= 1'b0;
         rx_parity_err <= 1'b0;
`endif
      end else begin
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
         rx_parity_err <= 1'b0;
`endif
         case (rx_state)
            RX_IDLE: begin
               if (!rx_s) begin
                  rx_os    <= '0;
                  rx_state <= RX_START;
               end
            end
            // Held-low line: wait for a return to idle before looking for a start bit.
            RX_BREAK: if (rx_s) rx_state <= RX_IDLE;
            RX_START: begin
               if (tick) begin
                  if (rx_os != OS_MID) begin
                     rx_os <= rx_os + 1'b1;
                  end else begin
                     rx_os    <= '0;
                     rx_bit   <= '0;
                     rx_state <= rx_s ? RX_IDLE : RX_DATA;
                  end
               end
            end
            default: begin
               if (tick) begin
                  if (rx_os != OS_LAST) begin
                     rx_os <= rx_os + 1'b1;
                  end else begin
                     rx_os <= '0;
                     case (rx_state)
                        RX_DATA: begin
                           rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
                           if (rx_bit != B_LAST) rx_bit <= rx_bit + 1'b1;
`ifdef UART_PARITY_EN
                           else rx_state <= RX_PAR;
`else
                           else rx_state <= RX_STOP;
`endif
                        end
`ifdef UART_PARITY_EN
                        RX_PAR: begin
                           rx_perr  <= rx_s ^ (^rx_sh) ^ (PARITY_ODD != 0);
                           rx_state <= RX_STOP;
                        end
`endif
                        RX_STOP: begin
                           if (rx_s) begin
`ifdef UART_PARITY_EN
                              if (rx_perr) begin
                                 rx_parity_err <= 1'b1;
                              end else begin
                                 rx_data  <= rx_sh;
                                 rx_valid <= 1'b1;
                              end
`else
                              rx_data  <= rx_sh;
                              rx_valid <= 1'b1;
`endif
                              rx_state <= RX_IDLE;
                           end else begin
                              rx_frame_err <= 1'b1;
`ifdef UART_PARITY_EN
                              rx_parity_err <= rx_perr;
`endif
                              rx_state <= RX_BREAK;
                           end
                        end
                        default: rx_state <= RX_IDLE;
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param at CLK_HZ=1.6 MHz, BAUD=10k, OVERSAMPLE=16
// (DIV=10, 160 sysclk per bit). Received words are checked against a
// queue filled when each frame is launched.

module tb_uart_core_param;

   localparam int BIT = 160;
`ifdef UART_PARITY_EN
   localparam int FR = 11;
`else
   localparam int FR = 10;
`endif

   logic       sysclk = 1'b0;
   logic       reset  = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, uart_tx, uart_rx;
   logic [7:0] rx_data;
   logic       rx_valid, rx_frame_err, rx_parity_err;
   logic       rx_drv = 1'b1;
   logic       loop = 1'b0;

   assign uart_rx = loop ? uart_tx : rx_drv;

   uart_core_param #(
      .CLK_HZ(1_600_000), .BAUD(10_000), .DATA_BITS(8),
      .OVERSAMPLE(16), .PARITY_ODD(0)
   ) dut (
      .sysclk(sysclk), .reset(reset),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .uart_tx(uart_tx), .uart_rx(uart_rx),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
   );

   always #5 sysclk = ~sysclk;

   int cyc = 0;
   always @(posedge sysclk) cyc <= cyc + 1;

   int checks = 0, errors = 0;
   int vcnt = 0, fecnt = 0, pecnt = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0]    d;
      logic [FR-1:0] fr;   // fr[i] = i-th bit on the line
   } vec_t;
   vec_t vt[4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // receive monitor / scoreboard
   initial forever begin
      @(negedge sysclk);
      if (rx_valid) begin
         vcnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got word %0h expected none", rx_data);
         end else begin
            chk("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
         end
      end
      if (rx_frame_err)  fecnt++;
      if (rx_parity_err) pecnt++;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_ready(input int lim);
      int n = 0;
      while (!tx_ready && n < lim) begin @(negedge sysclk); n++; end
   endtask

   // Send one word and check every bit mid-bit plus tx_ready timing.
   task automatic send_tx(input logic [7:0] d, input logic [FR-1:0] fr, input string nm);
      int t0;
      wait_ready(4000);
      @(negedge sysclk);
      tx_data = d; tx_valid = 1'b1;
      @(posedge sysclk);
      #1 tx_valid = 1'b0;
      t0 = cyc;
      chk({nm, "_ready_lo"}, {31'h0, tx_ready}, 0);
      if (loop) exp_q.push_back(d);
      for (int i = 0; i < FR; i++) begin
         while (cyc - t0 < BIT/2 + BIT*i) @(negedge sysclk);
         chk($sformatf("%s_bit%0d", nm, i), {31'h0, uart_tx}, {31'h0, fr[i]});
      end
      wait_ready(200);
      chk({nm, "_ready_hi"}, {31'h0, tx_ready}, 1);
      chk({nm, "_ready_time"},
          {31'h0, (cyc - t0 >= 151 + BIT*(FR-1)) && (cyc - t0 <= BIT*FR)}, 1);
   endtask

   // Bench-driven serial frame on uart_rx.
   task automatic drive_rx(input logic [7:0] d, input bit stop, input bit flip);
      logic [10:0] b;
      b = '0;
      b[8:1] = d;
`ifdef UART_PARITY_EN
      b[9]  = (^d) ^ flip;
      b[10] = stop;
`else
      b[9] = stop ^ (flip & 1'b0);
`endif
      for (int i = 0; i < FR; i++) begin
         @(negedge sysclk) rx_drv = b[i];
         repeat (BIT-1) @(negedge sysclk);
      end
   endtask

   initial begin
      int n, t, t0, t1, v0;
`ifdef UART_PARITY_EN
      vt[0] = '{8'hA5, 11'b1_0_10100101_0};
      vt[1] = '{8'h3C, 11'b1_0_00111100_0};
      vt[2] = '{8'h07, 11'b1_1_00000111_0};
      vt[3] = '{8'hFF, 11'b1_0_11111111_0};
`else
      vt[0] = '{8'hA5, 10'b1_10100101_0};
      vt[1] = '{8'h3C, 10'b1_00111100_0};
      vt[2] = '{8'h00, 10'b1_00000000_0};
      vt[3] = '{8'hFF, 10'b1_11111111_0};
`endif

      // reset state
      repeat (5) @(negedge sysclk);
      chk("rst_uart_tx",  {31'h0, uart_tx}, 1);
      chk("rst_tx_ready", {31'h0, tx_ready}, 1);
      chk("rst_rx_data",  {24'h0, rx_data}, 0);
      chk("rst_rx_flags", {29'h0, rx_valid, rx_frame_err, rx_parity_err}, 0);
      reset = 1'b1;

      // tick period
      n = 0;
      while (!dut.tick && n < 30) begin @(negedge sysclk); n++; end
      t = cyc;
      @(negedge sysclk);
      n = 0;
      while (!dut.tick && n < 30) begin @(negedge sysclk); n++; end
      chk("tick_period", cyc - t, 10);

      // table: TX framing with loopback into RX
      loop = 1'b1;
      for (int k = 0; k < 4; k++) send_tx(vt[k].d, vt[k].fr, $sformatf("vec%0d", k));
      repeat (20) @(negedge sysclk);
      chk("vec_rx_count", vcnt, 4);

      // back-to-back with tx_valid held
      v0 = vcnt;
      wait_ready(4000);
      @(negedge sysclk);
      tx_data = 8'h3C; tx_valid = 1'b1;
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hC3);
      @(posedge sysclk);
      #1 t0 = cyc;
      tx_data = 8'hC3;
      @(negedge sysclk);
      wait_ready(2000);
      @(posedge sysclk);
      #1 t1 = cyc;
      tx_valid = 1'b0;
      chk("b2b_start_low", {31'h0, uart_tx}, 0);
      chk("b2b_no_gap", {31'h0, (t1 - t0 >= 152 + BIT*(FR-1)) && (t1 - t0 <= BIT*FR + 1)}, 1);
      @(negedge sysclk);
      wait_ready(2000);
      repeat (20) @(negedge sysclk);
      chk("b2b_rx_count", vcnt - v0, 2);
      chk("b2b_no_err", fecnt + pecnt, 0);

      // start-bit glitch rejected, then a clean frame still received
      loop = 1'b0;
      v0 = vcnt;
      @(negedge sysclk) rx_drv = 1'b0;
      repeat (40) @(negedge sysclk);
      rx_drv = 1'b1;
      repeat (400) @(negedge sysclk);
      chk("glitch_no_valid", vcnt - v0, 0);
      chk("glitch_no_err", fecnt + pecnt, 0);
      exp_q.push_back(8'h96);
      drive_rx(8'h96, 1'b1, 1'b0);
      rx_drv = 1'b1;
      repeat (BIT) @(negedge sysclk);
      chk("post_glitch_rx", vcnt - v0, 1);

      // frame error, line held low, then recovery on a fresh start bit
      v0 = vcnt;
      drive_rx(8'h55, 1'b0, 1'b0);
      repeat (3*BIT) @(negedge sysclk);
      chk("break_frame_err", fecnt, 1);
      chk("break_no_valid", vcnt - v0, 0);
      chk("break_rx_data", {24'h0, rx_data}, 32'h96);
      chk("break_no_perr", pecnt, 0);
      rx_drv = 1'b1;
      repeat (2*BIT) @(negedge sysclk);
      chk("break_single_err", fecnt, 1);
      exp_q.push_back(8'h5A);
      drive_rx(8'h5A, 1'b1, 1'b0);
      rx_drv = 1'b1;
      repeat (BIT) @(negedge sysclk);
      chk("after_break_rx", vcnt - v0, 1);
      chk("after_break_data", {24'h0, rx_data}, 32'h5A);

      // reset in the middle of a TX data bit
      loop = 1'b1;
      wait_ready(4000);
      @(negedge sysclk);
      tx_data = 8'h00; tx_valid = 1'b1;
      @(posedge sysclk);
      #1 tx_valid = 1'b0;
      repeat (500) @(negedge sysclk);
      chk("mid_tx_low", {31'h0, uart_tx}, 0);
      reset = 1'b0;
      #1;
      chk("mid_rst_uart_tx",  {31'h0, uart_tx}, 1);
      chk("mid_rst_tx_ready", {31'h0, tx_ready}, 1);
      chk("mid_rst_rx_data",  {24'h0, rx_data}, 0);
      repeat (3) @(negedge sysclk);
      reset = 1'b1;
      repeat (3) @(negedge sysclk);
`ifdef UART_PARITY_EN
      send_tx(8'h01, 11'b1_1_00000001_0, "post_rst");
`else
      send_tx(8'h01, 10'b1_00000001_0, "post_rst");
`endif
      repeat (20) @(negedge sysclk);

`ifdef UART_PARITY_EN
      // flipped parity bit: one parity error, no word
      loop = 1'b0;
      v0 = vcnt;
      drive_rx(8'h07, 1'b1, 1'b1);
      rx_drv = 1'b1;
      repeat (BIT) @(negedge sysclk);
      chk("perr_count", pecnt, 1);
      chk("perr_no_valid", vcnt - v0, 0);
`endif

      chk("queue_empty", exp_q.size(), 0);
      chk("total_frame_err", fecnt, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
